// File: rtl/nabp_pkg.sv
// nabp_pkg: shared state encoding, default widths and fixed-point helper for the NABP buffers
package nabp_pkg;
    localparam int DATA_W_DEF = 12;
    localparam int S_W_DEF    = 9;
    localparam int ACCU_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [2:0] {idle_s, fill_s, swap_ready_s, shift_s, next_itr_s} state_t;

    function automatic logic [ACCU_W_DEF-FRAC_W_DEF-1:0] int_part(input logic [ACCU_W_DEF-1:0] a);
        return a[ACCU_W_DEF-1:FRAC_W_DEF];
    endfunction
endpackage

// File: rtl/nabp_tap_shifter.sv
// nabp_tap_shifter: N_TAPS register line with indexed write and one-position shift-down
module nabp_tap_shifter
    import nabp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_TAPS = 8,
    parameter int IDX_W  = 3
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     shift_en,
    input  logic [DATA_W-1:0]        shift_in,
    output logic [N_TAPS*DATA_W-1:0] taps
);
    // tap k takes tap k+1 on a shift, the top tap takes shift_in; otherwise optional indexed write
    always_ff @(posedge clk)
        if (!reset_n)
            taps <= '0;
        else if (shift_en)
            taps <= {shift_in, taps[N_TAPS*DATA_W-1:DATA_W]};
        else if (wr_en)
            taps[wr_idx*DATA_W +: DATA_W] <= wr_data;
endmodule

// File: rtl/nabp_swappable_buffer.sv
// nabp_swappable_buffer: fill/swap/shift tap buffer; NABP_SWAPPABLE_ZERO_FILL_EN shifts zeros in at the top tap
module nabp_swappable_buffer
    import nabp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_TAPS    = 8,
    parameter int S_W       = S_W_DEF,
    parameter int ACCU_W    = ACCU_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int SHIFT_LEN = 16
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ACCU_W-1:0]        sw_sh_accu_base,
    input  logic [ACCU_W-1:0]        sw_mp_accu_init,
    input  logic [ACCU_W-1:0]        sw_mp_accu_base,
    input  logic                     sw_swap,
    input  logic                     sw_next_itr_ack,
    input  logic [DATA_W-1:0]        fr_val,
    output logic                     sw_swap_ready,
    output logic                     sw_next_itr,
    output logic                     sw_pe_en,
    output logic [S_W-1:0]           fr_s_val,
    output logic [N_TAPS*DATA_W-1:0] pe_taps
);
    localparam int CNT_W = $clog2((SHIFT_LEN > N_TAPS ? SHIFT_LEN : N_TAPS) + 1);
    localparam int IDX_W = N_TAPS > 1 ? $clog2(N_TAPS) : 1;

    state_t            state, state_n;
    logic [ACCU_W-1:0] mp_accu, mp_base, sh_accu, sh_base, sh_next;
    logic [CNT_W-1:0]  cnt;
    logic              ack_ok, swap_ok, fill_done, shift_done, tap_wr, tap_shift;
    logic [DATA_W-1:0] shift_in;

    assign ack_ok     = sw_next_itr_ack && (state == idle_s || state == next_itr_s);
    assign swap_ok    = sw_swap && state == swap_ready_s;
    assign fill_done  = state == fill_s && cnt == CNT_W'(N_TAPS);
    assign shift_done = state == shift_s && cnt == CNT_W'(SHIFT_LEN - 1);
    assign sh_next    = sh_accu + sh_base;
    assign tap_wr     = state == fill_s && cnt != '0;
    assign tap_shift  = state == shift_s && int_part(sh_next) != int_part(sh_accu);

`ifdef NABP_SWAPPABLE_ZERO_FILL_EN
    assign shift_in = '0;
`else
    assign shift_in = pe_taps[N_TAPS*DATA_W-1 -: DATA_W];
`endif

    // state register
    always_ff @(posedge clk)
        state <= !reset_n ? idle_s : state_n;

    // next state and Moore handshake outputs
    always_comb begin
        state_n       = ack_ok ? fill_s : fill_done ? swap_ready_s : swap_ok ? shift_s :
                        shift_done ? next_itr_s : state;
        sw_swap_ready = state == swap_ready_s;
        sw_next_itr   = state == next_itr_s;
        sw_pe_en      = state == shift_s;
    end

    // accumulators, counter and read address; the first address is issued straight from the init value
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mp_accu  <= '0;
            mp_base  <= '0;
            sh_accu  <= '0;
            sh_base  <= '0;
            cnt      <= '0;
            fr_s_val <= '0;
        end else if (ack_ok) begin
            mp_base  <= sw_mp_accu_base;
            sh_base  <= sw_sh_accu_base;
            mp_accu  <= sw_mp_accu_init + sw_mp_accu_base;
            fr_s_val <= S_W'(int_part(sw_mp_accu_init));
            cnt      <= '0;
        end else if (swap_ok) begin
            sh_accu <= '0;
            cnt     <= '0;
        end else if (state == fill_s) begin
            cnt <= cnt + 1'b1;
            if (cnt < CNT_W'(N_TAPS - 1)) begin
                fr_s_val <= S_W'(int_part(mp_accu));
                mp_accu  <= mp_accu + mp_base;
            end
        end else if (state == shift_s) begin
            cnt     <= cnt + 1'b1;
            sh_accu <= sh_next;
        end
    end

    nabp_tap_shifter #(
        .DATA_W (DATA_W),
        .N_TAPS (N_TAPS),
        .IDX_W  (IDX_W)
    ) u_taps (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (tap_wr),
        .wr_idx   (IDX_W'(cnt - 1'b1)),
        .wr_data  (fr_val),
        .shift_en (tap_shift),
        .shift_in (shift_in),
        .taps     (pe_taps)
    );
endmodule

// File: tb/tb_nabp_swappable_buffer.sv
// tb_nabp_swappable_buffer: directed scoreboard bench for nabp_swappable_buffer
module tb_nabp_swappable_buffer;
    localparam int DW = 12;
    localparam int NT = 8;
    localparam int SW = 9;
    localparam int AW = 16;
`ifdef NABP_SWAPPABLE_ZERO_FILL_EN
    localparam logic [DW-1:0] EDGE = '0;
`else
    localparam logic [DW-1:0] EDGE = 12'd109;
`endif

    typedef struct packed {
        int             id;
        logic [2:0]     ctl;
        logic           ca;
        logic [SW-1:0]  addr;
        logic           ct;
        logic [NT*DW-1:0] taps;
    } exp_t;

    logic clk = 0, reset_n = 0, sw_swap = 0, sw_next_itr_ack = 0;
    logic [AW-1:0] sh_base = 0, mp_init = 0, mp_base = 0;
    logic [DW-1:0] fr_val = 0;
    logic sw_swap_ready, sw_next_itr, sw_pe_en;
    logic [SW-1:0] fr_s_val;
    logic [NT*DW-1:0] pe_taps;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0, step = 0;

    nabp_swappable_buffer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sw_sh_accu_base (sh_base),
        .sw_mp_accu_init (mp_init),
        .sw_mp_accu_base (mp_base),
        .sw_swap         (sw_swap),
        .sw_next_itr_ack (sw_next_itr_ack),
        .fr_val          (fr_val),
        .sw_swap_ready   (sw_swap_ready),
        .sw_next_itr     (sw_next_itr),
        .sw_pe_en        (sw_pe_en),
        .fr_s_val        (fr_s_val),
        .pe_taps         (pe_taps)
    );

    always #5 clk = ~clk;

    // filtered RAM stand-in: one-cycle read latency, data = address + 100
    always @(posedge clk) fr_val <= DW'(fr_s_val) + DW'(100);

    // monitor: compare the post-edge outputs against the oldest expectation
    always @(negedge clk)
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({sw_swap_ready, sw_next_itr, sw_pe_en} !== e.ctl) begin
                bad++;
                $display("FAIL ctl step %0d: got %b want %b", e.id, {sw_swap_ready, sw_next_itr, sw_pe_en}, e.ctl);
            end
            if (e.ca) begin
                total++;
                if (fr_s_val !== e.addr) begin
                    bad++;
                    $display("FAIL addr step %0d: got %0d want %0d", e.id, fr_s_val, e.addr);
                end
            end
            if (e.ct) begin
                total++;
                if (pe_taps !== e.taps) begin
                    bad++;
                    $display("FAIL taps step %0d: got %h want %h", e.id, pe_taps, e.taps);
                end
            end
        end

    function automatic exp_t ex(input logic [2:0] ctl, input logic ca, input int addr, input logic ct, input logic [NT*DW-1:0] t);
        exp_t r;
        r.id = 0; r.ctl = ctl; r.ca = ca; r.addr = SW'(addr); r.ct = ct; r.taps = t;
        return r;
    endfunction

    function automatic logic [NT*DW-1:0] pk(input int v[NT]);
        logic [NT*DW-1:0] r;
        for (int j = 0; j < NT; j++) r[j*DW +: DW] = DW'(v[j]);
        return r;
    endfunction

    // taps 102..109 after k shift-downs
    function automatic logic [NT*DW-1:0] exp_taps(input int k);
        logic [NT*DW-1:0] r;
        for (int j = 0; j < NT; j++) r[j*DW +: DW] = (j + k < NT) ? DW'(102 + j + k) : EDGE;
        return r;
    endfunction

    task automatic cyc(input logic ack, input logic swp, input logic rn, input exp_t x);
        sw_next_itr_ack = ack;
        sw_swap = swp;
        reset_n = rn;
        x.id = step;
        step++;
        q.push_back(x);
        @(posedge clk);
        #1;
        sw_next_itr_ack = 0;
        sw_swap = 0;
    endtask

    task automatic do_fill(input logic [AW-1:0] init, input logic [AW-1:0] base, input int a[NT], input logic [NT*DW-1:0] t, input bit g);
        mp_init = init;
        mp_base = base;
        sh_base = 16'h0080;
        cyc(1, g, 1, ex(3'b000, 1, a[0], 0, '0));
        mp_init = 16'h1234;
        mp_base = 16'h0777;
        sh_base = 16'h0300;
        for (int i = 1; i < NT; i++) cyc(g && i == 5, g && i == 3, 1, ex(3'b000, 1, a[i], 0, '0));
        cyc(0, g, 1, ex(3'b000, 1, a[NT-1], 0, '0));
        cyc(0, 0, 1, ex(3'b100, 1, a[NT-1], 1, t));
    endtask

    task automatic do_shift(input bit g);
        cyc(0, 0, 1, ex(3'b100, 1, 9, 1, exp_taps(0)));
        cyc(g, 1, 1, ex(3'b001, 1, 9, 1, exp_taps(0)));
        for (int i = 1; i < 16; i++) cyc(g && i == 6, g && i == 9, 1, ex(3'b001, 1, 9, 1, exp_taps(i / 2)));
        cyc(0, g, 1, ex(3'b010, 1, 9, 1, exp_taps(8)));
        cyc(0, 0, 1, ex(3'b010, 1, 9, 1, exp_taps(8)));
    endtask

    initial begin
        repeat (3) cyc(0, 0, 0, ex(3'b000, 1, 0, 1, '0));
        do_fill(16'h0280, 16'h0100, '{2, 3, 4, 5, 6, 7, 8, 9}, exp_taps(0), 0);
        do_shift(0);
        do_fill(16'h0280, 16'h0100, '{2, 3, 4, 5, 6, 7, 8, 9}, exp_taps(0), 1);
        do_shift(1);
        do_fill(16'hFF00, 16'h0180, '{255, 0, 2, 3, 5, 6, 8, 9},
                pk('{355, 100, 102, 103, 105, 106, 108, 109}), 0);
        cyc(0, 1, 1, ex(3'b001, 1, 9, 0, '0));
        for (int i = 1; i < 5; i++) cyc(0, 0, 1, ex(3'b001, 1, 9, 0, '0));
        cyc(0, 0, 0, ex(3'b000, 1, 0, 1, '0));
        do_fill(16'h0280, 16'h0100, '{2, 3, 4, 5, 6, 7, 8, 9}, exp_taps(0), 0);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
